// File: rtl/interrupt_unit_pkg.sv
// Shared CPU package: interrupt FSM encoding, cause codes and default
// handler addresses used by the interrupt unit and its clients.
package interrupt_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SVC_INT  = 2'd1,
        SVC_NMI  = 2'd2,
        SVC_NEST = 2'd3
    } irq_state_e;

    localparam logic [2:0]  CAUSE_NMI       = 3'd4;
    localparam logic [2:0]  CAUSE_SPURIOUS  = 3'd7;

    localparam logic [31:0] NMI_VEC_DEFAULT = 32'h0000_0100;
    localparam logic [31:0] INT_VEC_DEFAULT = 32'h0000_0080;

    // Handler address for a cause code: NMI has its own entry, sources 0-3
    // get 8-byte slots above the maskable base, spurious lands on the base.
    function automatic logic [31:0] cause_to_vector(input logic [2:0]  c,
                                                    input logic [31:0] nmi_vec,
                                                    input logic [31:0] int_vec);
        logic [31:0] v;
        case (c)
            CAUSE_NMI:                 v = nmi_vec;
            3'd0, 3'd1, 3'd2, 3'd3:    v = int_vec + (32'(c) << 3);
            default:                   v = int_vec;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/interrupt_unit_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt unit: edge-captured maskable and non-maskable requests, a
// single level of NMI nesting inside a maskable service, EPC/cause capture
// and vector generation for the Controller.
module interrupt_unit
    import interrupt_unit_pkg::*;
#(
    parameter int          NSRC    = 4,
    parameter logic [31:0] NMI_VEC = NMI_VEC_DEFAULT,
    parameter logic [31:0] INT_VEC = INT_VEC_DEFAULT
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NSRC-1:0] irq,
    input  logic            nmi_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            isInterrupted,
    input  logic            INA,
    input  logic [31:0]     PCIn,
    input  logic            eret,
    output logic            INT,
    output logic            NMI,
    output logic            INTD,
    output logic [31:0]     EPC,
    output logic [2:0]      cause,
    output logic [31:0]     vector,
    output logic [NSRC-1:0] mask
);

    localparam int IW = $clog2(NSRC);

    irq_state_e      state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] irq_rise;
    logic            nmi_q;
    logic            nmi_pend;
    logic            nmi_clr;
    logic            nmi_rise;
    logic            isInterrupted_q;
    logic            ack;
    logic [31:0]     shadow_epc;
    logic [2:0]      shadow_cause;
    logic [IW-1:0]   prio_idx;
    logic            prio_valid;

    assign irq_rise = irq & ~irq_q;
    assign nmi_rise = nmi_in & ~nmi_q;
    assign ack      = isInterrupted & ~isInterrupted_q;

    irq_prio_enc #(
        .N  (NSRC),
        .IW (IW)
    ) u_prio_enc (
        .req   (pend & mask),
        .idx   (prio_idx),
        .valid (prio_valid)
    );

    // Decide which pending bits the current acknowledge consumes.
    always_comb begin
        pend_clr = '0;
        nmi_clr  = 1'b0;
        if (ack && INA && state == IDLE && prio_valid) begin
            pend_clr[prio_idx] = 1'b1;
        end
        if (ack && !INA && (state == IDLE || state == SVC_INT)) begin
            nmi_clr = 1'b1;
        end
    end

    // Request and disable lines derive only from registered state.
    always_comb begin
        INT  = (state == IDLE) && |(pend & mask);
        NMI  = nmi_pend && (state == IDLE || state == SVC_INT);
        INTD = (state != IDLE);
    end

    assign vector = cause_to_vector(cause, NMI_VEC, INT_VEC);

    // Edge capture, pending bookkeeping, mask register and the service FSM;
    // a fresh edge wins over a same-cycle clear so no request is lost.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            irq_q           <= '0;
            nmi_q           <= 1'b0;
            isInterrupted_q <= 1'b0;
            pend            <= '0;
            nmi_pend        <= 1'b0;
            mask            <= '0;
            EPC             <= '0;
            cause           <= '0;
            shadow_epc      <= '0;
            shadow_cause    <= '0;
        end else begin
            irq_q           <= irq;
            nmi_q           <= nmi_in;
            isInterrupted_q <= isInterrupted;
            pend            <= (pend & ~pend_clr) | irq_rise;
            nmi_pend        <= (nmi_pend & ~nmi_clr) | nmi_rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            case (state)
                IDLE: begin
                    if (ack) begin
                        EPC <= PCIn;
                        if (INA) begin
                            cause <= prio_valid ? 3'(prio_idx) : CAUSE_SPURIOUS;
                            state <= SVC_INT;
                        end else begin
                            cause <= CAUSE_NMI;
                            state <= SVC_NMI;
                        end
                    end
                end
                SVC_INT: begin
                    if (ack && !INA) begin
                        shadow_epc   <= EPC;
                        shadow_cause <= cause;
                        EPC          <= PCIn;
                        cause        <= CAUSE_NMI;
                        state        <= SVC_NEST;
                    end else if (eret) begin
                        state <= IDLE;
                    end
                end
                SVC_NMI: begin
                    if (eret) begin
                        state <= IDLE;
                    end
                end
                SVC_NEST: begin
                    if (eret) begin
                        EPC   <= shadow_epc;
                        cause <= shadow_cause;
                        state <= SVC_INT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ack_eret_exclusive: assert property (@(posedge Clk) disable iff (Rst) !(ack && eret));

endmodule

// File: tb/tb_interrupt_unit.sv
// Testbench for interrupt_unit: directed vectors with literal expectations
// plus a per-cycle comparison against a service-stack reference model.
module tb_interrupt_unit;
    import interrupt_unit_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  irq;
    logic        nmi_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        isInterrupted;
    logic        INA;
    logic [31:0] PCIn;
    logic        eret;
    logic        INT;
    logic        NMI;
    logic        INTD;
    logic [31:0] EPC;
    logic [2:0]  cause;
    logic [31:0] vector;
    logic [3:0]  mask;

    int vec_count = 0;
    int err_count = 0;

    interrupt_unit dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .irq           (irq),
        .nmi_in        (nmi_in),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .isInterrupted (isInterrupted),
        .INA           (INA),
        .PCIn          (PCIn),
        .eret          (eret),
        .INT           (INT),
        .NMI           (NMI),
        .INTD          (INTD),
        .EPC           (EPC),
        .cause         (cause),
        .vector        (vector),
        .mask          (mask)
    );

    always #5 Clk = ~Clk;

    // Reference model: a stack of active services (0 = maskable, 1 = NMI)
    // and a stack of saved {EPC, cause} pairs for nested entries.
    bit [3:0]  m_pend, m_mask, m_prev_irq, m_rise;
    bit        m_nmi_pend, m_prev_nmi, m_prev_ii, m_nrise, m_ack;
    bit [31:0] m_epc;
    bit [2:0]  m_cause;
    int        m_stack[$];
    bit [34:0] m_saved[$];
    bit        model_ready = 1'b0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_pend = '0; m_mask = '0; m_nmi_pend = 1'b0;
            m_epc = '0; m_cause = '0;
            m_stack.delete(); m_saved.delete();
            m_prev_irq = '0; m_prev_nmi = 1'b0; m_prev_ii = 1'b0;
            model_ready = 1'b1;
        end else begin
            m_rise  = irq & ~m_prev_irq;
            m_nrise = nmi_in && !m_prev_nmi;
            m_ack   = isInterrupted && !m_prev_ii;
            if (m_ack && INA && m_stack.size() == 0) begin
                m_epc   = PCIn;
                m_cause = 3'd7;
                for (int i = 3; i >= 0; i--) begin
                    if (m_pend[i] && m_mask[i]) m_cause = 3'(i);
                end
                if (m_cause != 3'd7) m_pend[m_cause[1:0]] = 1'b0;
                m_stack.push_back(0);
            end else if (m_ack && !INA &&
                         (m_stack.size() == 0 || (m_stack.size() == 1 && m_stack[0] == 0))) begin
                if (m_stack.size() == 1) m_saved.push_back({m_epc, m_cause});
                m_epc      = PCIn;
                m_cause    = 3'd4;
                m_nmi_pend = 1'b0;
                m_stack.push_back(1);
            end else if (eret && m_stack.size() != 0) begin
                void'(m_stack.pop_back());
                if (m_stack.size() != 0) {m_epc, m_cause} = m_saved.pop_back();
            end
            m_pend     = m_pend | m_rise;
            m_nmi_pend = m_nmi_pend | m_nrise;
            if (mask_we) m_mask = mask_wdata;
            m_prev_irq = irq;
            m_prev_nmi = nmi_in;
            m_prev_ii  = isInterrupted;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every negedge, compare all outputs with what the model says they must be.
    always @(negedge Clk) begin
        if (model_ready) begin
            bit        e_int, e_nmi;
            bit [31:0] e_vec;
            e_int = (m_stack.size() == 0) && (|(m_pend & m_mask));
            e_nmi = m_nmi_pend && (m_stack.size() == 0 ||
                                   (m_stack.size() == 1 && m_stack[0] == 0));
            if (m_cause == 3'd4)      e_vec = 32'h100;
            else if (m_cause <= 3'd3) e_vec = 32'h80 + 32'(m_cause) * 32'd8;
            else                      e_vec = 32'h80;
            check_output("model_INT",    32'(INT),    32'(e_int));
            check_output("model_NMI",    32'(NMI),    32'(e_nmi));
            check_output("model_INTD",   32'(INTD),   32'(m_stack.size() != 0));
            check_output("model_EPC",    EPC,         m_epc);
            check_output("model_cause",  32'(cause),  32'(m_cause));
            check_output("model_vector", vector,      e_vec);
            check_output("model_mask",   32'(mask),   32'(m_mask));
        end
    end

    // Drive one cycle of inputs starting at a negedge, then wait for the next.
    task automatic apply_stimulus(input logic [3:0] irq_v, input logic nmi_v,
                                  input logic we_v, input logic [3:0] wd_v,
                                  input logic ii_v, input logic ina_v,
                                  input logic [31:0] pc_v, input logic eret_v);
        irq = irq_v; nmi_in = nmi_v; mask_we = we_v; mask_wdata = wd_v;
        isInterrupted = ii_v; INA = ina_v; PCIn = pc_v; eret = eret_v;
        @(negedge Clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic write_mask(input logic [3:0] v);
        apply_stimulus(4'b0, 1'b0, 1'b1, v, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic take(input logic ina_v, input logic [31:0] pc_v);
        apply_stimulus(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, ina_v, pc_v, 1'b0);
    endtask

    task automatic do_eret();
        apply_stimulus(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst = 1'b1;
        irq = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        isInterrupted = 1'b0; INA = 1'b0; PCIn = '0; eret = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        check_output("rst_INT",  32'(INT),  32'h0);
        check_output("rst_NMI",  32'(NMI),  32'h0);
        check_output("rst_INTD", 32'(INTD), 32'h0);
        check_output("rst_EPC",  EPC,       32'h0);
        check_output("rst_mask", 32'(mask), 32'h0);

        // Single maskable source, full mask.
        write_mask(4'b1111);
        apply_stimulus(4'b0100, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("r030_INT_pre", 32'(INT), 32'h1);
        take(1'b1, 32'h40);
        check_output("r030_cause",  32'(cause), 32'h2);
        check_output("r030_EPC",    EPC,        32'h40);
        check_output("r030_vector", vector,     32'h90);
        check_output("r030_INTD",   32'(INTD),  32'h1);
        do_eret();
        check_output("r030_INT_post", 32'(INT), 32'h0);

        // Two simultaneous sources through a partial mask.
        write_mask(4'b1010);
        apply_stimulus(4'b1010, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        take(1'b1, 32'h10);
        check_output("r031_cause1", 32'(cause), 32'h1);
        do_eret();
        take(1'b1, 32'h14);
        check_output("r031_cause2",  32'(cause), 32'h3);
        check_output("r031_vector2", vector,     32'h98);
        do_eret();

        // NMI nested inside a maskable service.
        write_mask(4'b1111);
        apply_stimulus(4'b0001, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        take(1'b1, 32'h40);
        apply_stimulus(4'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("r032_NMI_pre", 32'(NMI), 32'h1);
        take(1'b0, 32'h88);
        check_output("r032_EPC_nest",   EPC,        32'h88);
        check_output("r032_cause_nest", 32'(cause), 32'h4);
        check_output("r032_NMI_nest",   32'(NMI),   32'h0);
        check_output("r032_vec_nest",   vector,     32'h100);
        do_eret();
        check_output("r032_EPC_back",   EPC,        32'h40);
        check_output("r032_cause_back", 32'(cause), 32'h0);
        check_output("r032_INTD_back",  32'(INTD),  32'h1);
        do_eret();

        // Level held three cycles gives one acknowledge only.
        apply_stimulus(4'b1010, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) take(1'b1, 32'h60);
        check_output("r033_cause", 32'(cause), 32'h1);
        idle_cycle();
        do_eret();
        check_output("r033_INT_left", 32'(INT), 32'h1);
        take(1'b1, 32'h64);
        check_output("r033_cause2", 32'(cause), 32'h3);
        do_eret();

        // New edge in the same cycle its pend bit is consumed.
        apply_stimulus(4'b0001, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycle();
        apply_stimulus(4'b0001, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 32'h70, 1'b0);
        check_output("r023_cause", 32'(cause), 32'h0);
        do_eret();
        check_output("r023_INT_kept", 32'(INT), 32'h1);
        take(1'b1, 32'h74);
        do_eret();
        check_output("r023_INT_gone", 32'(INT), 32'h0);

        // NMI from idle, ignored acks in SVC_NMI, then reset mid-service.
        apply_stimulus(4'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("nmi_pre", 32'(NMI), 32'h1);
        take(1'b0, 32'h200);
        check_output("nmi_cause", 32'(cause), 32'h4);
        check_output("nmi_EPC",   EPC,        32'h200);
        idle_cycle();
        take(1'b1, 32'h300);
        check_output("nmi_ign_EPC", EPC, 32'h200);
        apply_stimulus(4'b0101, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(4'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycle();
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_output("r035_INT",   32'(INT),  32'h0);
        check_output("r035_NMI",   32'(NMI),  32'h0);
        check_output("r035_INTD",  32'(INTD), 32'h0);
        check_output("r035_EPC",   EPC,       32'h0);
        write_mask(4'b1111);
        check_output("r035_pend_clear", 32'(INT), 32'h0);
        check_output("r035_nmi_clear",  32'(NMI), 32'h0);

        // Spurious acknowledge, then eret ignored in IDLE.
        take(1'b1, 32'h500);
        check_output("spur_cause",  32'(cause), 32'h7);
        check_output("spur_vector", vector,     32'h80);
        do_eret();
        do_eret();
        check_output("idle_eret_EPC", EPC, 32'h500);

        // Masked source stays pending until unmasked.
        write_mask(4'b0000);
        apply_stimulus(4'b0001, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycle();
        check_output("r034_INT_masked", 32'(INT), 32'h0);
        write_mask(4'b0001);
        check_output("r034_INT_unmask", 32'(INT), 32'h1);
        take(1'b1, 32'h600);
        check_output("r034_cause", 32'(cause), 32'h0);
        do_eret();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
